mem_port_arbiter: RTL and testbench

- Shares the processor's single unified memory port between the instruction-fetch stage (IF) and the load/store stage (MEM).
- Sits between the pipeline stages and the memory model inside proc_top.
- Sequences each access through grant, latency wait and response.
- Raises per-stage stall signals so the pipeline holds while its access is outstanding.

---
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Unified memory port arbiter between instruction fetch and load/store.
// One access in flight at a time: grant, fixed-latency wait, one-cycle response.
module mem_port_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MEM_LATENCY     = 1,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_ready,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_be,
    output logic                dm_ready,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                stall_if,
    output logic                stall_mem,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [3:0] LAT   = 4'(MEM_LATENCY);
    localparam logic [3:0] MAX_S = 4'(MAX_DATA_STREAK);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic       owner_dm_q;
    logic [3:0] cnt_q;
    logic [3:0] streak_q;
    logic       grant_if;
    logic       grant_dm;

    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = dm_req & ~dm_ready;

    always_comb begin
        state_d  = state_q;
        grant_if = 1'b0;
        grant_dm = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Data has priority unless a waiting fetch hit its streak limit
                if (dm_req && (!if_req || streak_q != MAX_S)) begin
                    grant_dm = 1'b1;
                end else if (if_req) begin
                    grant_if = 1'b1;
                end
                if (grant_if || grant_dm) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_dm_q <= 1'b0;
            cnt_q      <= '0;
            streak_q   <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
            if_ready   <= 1'b0;
            dm_ready   <= 1'b0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
        end else begin
            state_q  <= state_d;
            mem_en   <= 1'b0;
            if_ready <= 1'b0;
            dm_ready <= 1'b0;

            if (grant_dm) begin
                mem_en     <= 1'b1;
                mem_we     <= dm_we;
                mem_addr   <= dm_addr;
                mem_wdata  <= dm_wdata;
                mem_be     <= dm_be;
                owner_dm_q <= 1'b1;
                cnt_q      <= LAT;
                if (!if_req) begin
                    streak_q <= '0;
                end else if (streak_q != MAX_S) begin
                    streak_q <= streak_q + 4'd1;
                end
            end else if (grant_if) begin
                mem_en     <= 1'b1;
                mem_we     <= 1'b0;
                mem_addr   <= if_addr;
                mem_wdata  <= '0;
                mem_be     <= {BE_W{1'b1}};
                owner_dm_q <= 1'b0;
                cnt_q      <= LAT;
                streak_q   <= '0;
            end

            if (state_q == WAIT) begin
                if (cnt_q == 4'd0) begin
                    if (owner_dm_q) begin
                        dm_ready <= 1'b1;
                        if (!mem_we) begin
                            dm_rdata <= mem_rdata;
                        end
                    end else begin
                        if_ready <= 1'b1;
                        if_rdata <= mem_rdata;
                    end
                end else begin
                    cnt_q <= cnt_q - 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: cycle table at latency 1, then directed
// sequences for starvation, reset mid-access and latency 3.
module tb_mem_port_arbiter;

    localparam logic [31:0] K  = 32'h20080005;
    localparam logic [31:0] DB = 32'hDEADBEEF;
    localparam logic [31:0] Z  = 32'h0;
    localparam logic [3:0]  F  = 4'hF;
    localparam logic [3:0]  B0 = 4'h0;
    localparam logic [3:0]  B3 = 4'h3;
    localparam bit O = 1'b0;
    localparam bit I = 1'b1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ready;
    logic [31:0] if_rdata;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [3:0]  dm_be = '0;
    logic        dm_ready;
    logic [31:0] dm_rdata;
    logic        stall_if;
    logic        stall_mem;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;

    logic        l3_if_req = 1'b0;
    logic [31:0] l3_if_addr = '0;
    logic        l3_if_ready;
    logic [31:0] l3_if_rdata;
    logic        l3_dm_ready;
    logic [31:0] l3_dm_rdata;
    logic        l3_stall_if;
    logic        l3_stall_mem;
    logic        l3_mem_en;
    logic        l3_mem_we;
    logic [31:0] l3_mem_addr;
    logic [31:0] l3_mem_wdata;
    logic [3:0]  l3_mem_be;
    logic [31:0] l3_mem_rdata;

    mem_port_arbiter #(
        .MEM_LATENCY(1),
        .MAX_DATA_STREAK(4)
    ) u1 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .if_ready(if_ready), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_be(dm_be),
        .dm_ready(dm_ready), .dm_rdata(dm_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(
        .MEM_LATENCY(3),
        .MAX_DATA_STREAK(4)
    ) u3 (
        .clk(clk), .rst(rst),
        .if_req(l3_if_req), .if_addr(l3_if_addr),
        .if_ready(l3_if_ready), .if_rdata(l3_if_rdata),
        .dm_req(1'b0), .dm_we(1'b0), .dm_addr(32'h0),
        .dm_wdata(32'h0), .dm_be(4'h0),
        .dm_ready(l3_dm_ready), .dm_rdata(l3_dm_rdata),
        .stall_if(l3_stall_if), .stall_mem(l3_stall_mem),
        .mem_en(l3_mem_en), .mem_we(l3_mem_we), .mem_addr(l3_mem_addr),
        .mem_wdata(l3_mem_wdata), .mem_be(l3_mem_be),
        .mem_rdata(l3_mem_rdata)
    );

    // Memory models: read data is valid only exactly LATENCY cycles after mem_en
    logic [3:0] p1 = '0;
    logic [3:0] p3 = '0;
    always @(posedge clk) begin
        p1 <= {p1[2:0], mem_en};
        p3 <= {p3[2:0], l3_mem_en};
    end
    assign mem_rdata    = p1[0] ? (mem_addr ^ K) : 32'hBAD0BAD0;
    assign l3_mem_rdata = p3[2] ? (l3_mem_addr ^ K) : 32'hBAD0BAD0;

    typedef struct {
        bit          rst;
        bit          ir;
        logic [31:0] ia;
        bit          dr;
        bit          dw;
        logic [31:0] da;
        logic [31:0] dd;
        logic [3:0]  db;
        bit          e_en;
        bit          e_we;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        bit          e_ifr;
        logic [31:0] e_ifd;
        bit          e_dmr;
        logic [31:0] e_dmd;
        bit          e_sif;
        bit          e_sm;
    } vec_t;

    vec_t tv[19];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] A40  = 32'h40;
    localparam logic [31:0] A100 = 32'h100;
    localparam logic [31:0] A200 = 32'h200;
    localparam logic [31:0] D05  = 32'h20080005;
    localparam logic [31:0] D45  = 32'h20080045;
    localparam logic [31:0] D105 = 32'h20080105;

    logic [31:0] exp_addr[6];
    int ng;
    int lat;
    bit seen;

    initial begin
        tv[0]  = '{I,O,Z,O,O,Z,Z,B0,       O,O,Z,B0,Z,O,Z,O,Z,O,O};
        tv[1]  = '{O,I,Z,O,O,Z,Z,B0,       O,O,Z,B0,Z,O,Z,O,Z,I,O};
        tv[2]  = '{O,I,Z,O,O,Z,Z,B0,       I,O,Z,F,Z,O,Z,O,Z,I,O};
        tv[3]  = '{O,I,Z,O,O,Z,Z,B0,       O,O,Z,F,Z,O,Z,O,Z,I,O};
        tv[4]  = '{O,I,Z,O,O,Z,Z,B0,       O,O,Z,F,Z,I,D05,O,Z,O,O};
        tv[5]  = '{O,O,Z,O,O,Z,Z,B0,       O,O,Z,F,Z,O,D05,O,Z,O,O};
        tv[6]  = '{O,I,A40,I,O,A100,Z,F,   O,O,Z,F,Z,O,D05,O,Z,I,I};
        tv[7]  = '{O,I,A40,I,O,A100,Z,F,   I,O,A100,F,Z,O,D05,O,Z,I,I};
        tv[8]  = '{O,I,A40,I,O,A100,Z,F,   O,O,A100,F,Z,O,D05,O,Z,I,I};
        tv[9]  = '{O,I,A40,I,O,A100,Z,F,   O,O,A100,F,Z,O,D05,I,D105,I,O};
        tv[10] = '{O,I,A40,O,O,A100,Z,F,   O,O,A100,F,Z,O,D05,O,D105,I,O};
        tv[11] = '{O,I,A40,O,O,A100,Z,F,   I,O,A40,F,Z,O,D05,O,D105,I,O};
        tv[12] = '{O,I,A40,O,O,A100,Z,F,   O,O,A40,F,Z,O,D05,O,D105,I,O};
        tv[13] = '{O,I,A40,O,O,A100,Z,F,   O,O,A40,F,Z,I,D45,O,D105,O,O};
        tv[14] = '{O,O,A40,I,I,A200,DB,B3, O,O,A40,F,Z,O,D45,O,D105,O,I};
        tv[15] = '{O,O,A40,I,I,A200,DB,B3, I,I,A200,B3,DB,O,D45,O,D105,O,I};
        tv[16] = '{O,O,A40,I,I,A200,DB,B3, O,I,A200,B3,DB,O,D45,O,D105,O,I};
        tv[17] = '{O,O,A40,I,I,A200,DB,B3, O,I,A200,B3,DB,O,D45,I,D105,O,O};
        tv[18] = '{O,O,Z,O,O,Z,Z,B0,       O,I,A200,B3,DB,O,D45,O,D105,O,O};

        exp_addr[0] = 32'h100;
        exp_addr[1] = 32'h104;
        exp_addr[2] = 32'h108;
        exp_addr[3] = 32'h10C;
        exp_addr[4] = 32'h80;
        exp_addr[5] = 32'h110;

        rst = 1'b1;
        tick();

        for (int i = 0; i < 19; i++) begin
            rst      = tv[i].rst;
            if_req   = tv[i].ir;
            if_addr  = tv[i].ia;
            dm_req   = tv[i].dr;
            dm_we    = tv[i].dw;
            dm_addr  = tv[i].da;
            dm_wdata = tv[i].dd;
            dm_be    = tv[i].db;
            #1;
            chk($sformatf("r%0d mem_en", i), 32'(mem_en), 32'(tv[i].e_en));
            chk($sformatf("r%0d mem_we", i), 32'(mem_we), 32'(tv[i].e_we));
            chk($sformatf("r%0d mem_addr", i), mem_addr, tv[i].e_addr);
            chk($sformatf("r%0d mem_be", i), 32'(mem_be), 32'(tv[i].e_be));
            chk($sformatf("r%0d mem_wdata", i), mem_wdata, tv[i].e_wd);
            chk($sformatf("r%0d if_ready", i), 32'(if_ready), 32'(tv[i].e_ifr));
            chk($sformatf("r%0d if_rdata", i), if_rdata, tv[i].e_ifd);
            chk($sformatf("r%0d dm_ready", i), 32'(dm_ready), 32'(tv[i].e_dmr));
            chk($sformatf("r%0d dm_rdata", i), dm_rdata, tv[i].e_dmd);
            chk($sformatf("r%0d stall_if", i), 32'(stall_if), 32'(tv[i].e_sif));
            chk($sformatf("r%0d stall_mem", i), 32'(stall_mem), 32'(tv[i].e_sm));
            tick();
        end

        // Starvation guard: four data grants, then the waiting fetch
        if_req  = 1'b1;
        if_addr = 32'h80;
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'h100;
        dm_be   = 4'hF;
        ng = 0;
        for (int c = 0; c < 80 && ng < 6; c++) begin
            tick();
            chk("ready_exclusive", 32'(if_ready & dm_ready), 32'h0);
            if (mem_en) begin
                chk($sformatf("streak_grant%0d", ng), mem_addr, exp_addr[ng]);
                ng++;
            end
            if (dm_ready) dm_addr = dm_addr + 32'd4;
            if (if_ready) if_req = 1'b0;
        end
        chk("streak_grant_count", 32'(ng), 32'd6);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            if (dm_ready) begin
                seen   = 1'b1;
                dm_req = 1'b0;
                chk("streak_last_rdata", dm_rdata, 32'h20080115);
            end
        end
        chk("streak_drain", 32'(seen), 32'h1);
        tick();

        // Reset while the access is waiting
        if_req  = 1'b1;
        if_addr = 32'h44;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            tick();
            if (mem_en) seen = 1'b1;
        end
        chk("rst_mid_grant", 32'(seen), 32'h1);
        rst = 1'b1;
        tick();
        chk("rst_mid_flags",
            32'({mem_en, mem_we, if_ready, dm_ready}), 32'h0);
        chk("rst_mid_addr", mem_addr, 32'h0);
        chk("rst_mid_wdata", mem_wdata, 32'h0);
        chk("rst_mid_be", 32'(mem_be), 32'h0);
        chk("rst_mid_if_rdata", if_rdata, 32'h0);
        chk("rst_mid_dm_rdata", dm_rdata, 32'h0);
        chk("rst_mid_stall_if", 32'(stall_if), 32'h1);
        rst = 1'b0;
        lat = 0;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            tick();
            if (if_ready) lat = k;
        end
        chk("rst_restart_cycle", 32'(lat), 32'd3);
        chk("rst_restart_rdata", if_rdata, 32'h20080041);
        if_req = 1'b0;
        tick();

        // Latency 3: single fetch
        l3_if_req  = 1'b1;
        l3_if_addr = 32'h300;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            tick();
            if (l3_mem_en) seen = 1'b1;
        end
        chk("l3_grant", 32'(seen), 32'h1);
        chk("l3_grant_addr", l3_mem_addr, 32'h300);
        lat = 0;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            tick();
            if (l3_if_ready) lat = k;
            else chk($sformatf("l3_addr_hold%0d", k), l3_mem_addr, 32'h300);
        end
        chk("l3_ready_cycle", 32'(lat), 32'd4);
        chk("l3_rdata", l3_if_rdata, 32'h20080305);
        l3_if_req = 1'b0;
        tick();
        chk("l3_ready_pulse", 32'(l3_if_ready), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
